// File: rtl/wb_test_slave_if.sv
// Wishbone classic bus bundle between a random-traffic master and the test slave.
interface wb_test_slave_if;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport master (
        output dat_w, adr, we, sel, cyc, stb,
        input  dat_r, ack
    );

    modport slave (
        input  dat_w, adr, we, sel, cyc, stb,
        output dat_r, ack
    );
endinterface

// File: rtl/wb_test_slave.sv
// Wishbone classic test slave: small word memory, LFSR-driven wait states,
// transfer counters, sticky protocol-violation and quota-reached flags.
module wb_test_slave #(
    parameter int unsigned id      = 0,
    parameter int unsigned aw_mem  = 4,
    parameter int unsigned p       = 4,
    parameter int unsigned nreads  = 10,
    parameter int unsigned nwrites = 10
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    wb_test_slave_if.slave        bus,
    output logic                  err,
    output logic                  tend
);

    localparam int unsigned MEM_WORDS = 1 << aw_mem;
    localparam logic [15:0] SEED_RAW  = 16'hACE1 ^ 16'(id);
    localparam logic [15:0] SEED      = (SEED_RAW == 16'd0) ? 16'd1 : SEED_RAW;
    localparam logic [15:0] P_DIV     = 16'(p);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_latch;
    logic                w_go;
    logic                w_hit;
    logic                w_viol;
    logic                w_fb;
    logic [aw_mem-1:0]   w_idx;

    logic [31:0]         r_req_adr;
    logic [31:0]         r_req_dat;
    logic                r_req_we;
    logic [3:0]          r_req_sel;
    logic [31:0]         r_mem [MEM_WORDS];
    logic [15:0]         r_lfsr;
    logic [31:0]         r_rcount;
    logic [31:0]         r_wcount;
    logic                r_ack;
    logic [31:0]         r_dat_r;
    logic                r_err;
    logic                r_tend;

    assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_hit  = (r_lfsr % P_DIV) == 16'd0;
    assign w_idx  = r_req_adr[aw_mem-1:0];

    // Any of: strobe outside a cycle, request changed while waiting, strobe dropped mid-wait.
    assign w_viol = (bus.stb && !bus.cyc) ||
                    ((r_state == ST_WAIT) && bus.cyc && bus.stb &&
                     ((bus.adr != r_req_adr) || (bus.we != r_req_we) ||
                      (bus.sel != r_req_sel) || (bus.dat_w != r_req_dat))) ||
                    ((r_state == ST_WAIT) && bus.cyc && !bus.stb);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Abort on cyc drop takes priority over a wait-state hit.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_go        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cyc && bus.stb) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hit) begin
                    w_go        = 1'b1;
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_req_adr <= '0;
            r_req_dat <= '0;
            r_req_we  <= 1'b0;
            r_req_sel <= '0;
            r_mem     <= '{default: '0};
            r_lfsr    <= SEED;
            r_rcount  <= '0;
            r_wcount  <= '0;
            r_ack     <= 1'b0;
            r_dat_r   <= '0;
            r_err     <= 1'b0;
            r_tend    <= 1'b0;
        end else begin
            if (w_latch) begin
                r_req_adr <= bus.adr;
                r_req_dat <= bus.dat_w;
                r_req_we  <= bus.we;
                r_req_sel <= bus.sel;
            end
            if (r_state == ST_WAIT) r_lfsr <= {r_lfsr[14:0], w_fb};
            r_ack   <= w_go;
            r_dat_r <= (w_go && !r_req_we) ? r_mem[w_idx] : 32'd0;
            if (w_go && r_req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (r_req_sel[i]) r_mem[w_idx][8*i +: 8] <= r_req_dat[8*i +: 8];
                end
                r_wcount <= r_wcount + 32'd1;
            end
            if (w_go && !r_req_we) r_rcount <= r_rcount + 32'd1;
            if (w_viol) r_err <= 1'b1;
            if ((r_rcount >= 32'(nreads)) && (r_wcount >= 32'(nwrites))) r_tend <= 1'b1;
        end
    end

    assign bus.ack   = r_ack;
    assign bus.dat_r = r_dat_r;
    assign err       = r_err;
    assign tend      = r_tend;

endmodule
